// File: rtl/apb_timer_master.sv
// apb_timer_master: valid/ready command stream to APB requester for timer_top.
// One command is outstanding at a time, and each command returns one response.
// Optional hang protection is built with `define APB_TMO_EN. It aborts an
// ACCESS phase after TIMEOUT_CYCLES cycles with tim_pready low.
module apb_timer_master #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_strb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_tmo,
    output logic                  tim_psel,
    output logic                  tim_penable,
    output logic                  tim_pwrite,
    output logic [ADDR_W-1:0]     tim_paddr,
    output logic [DATA_W-1:0]     tim_pwdata,
    output logic [DATA_W/8-1:0]   tim_pstrb,
    input  logic [DATA_W-1:0]     tim_prdata,
    input  logic                  tim_pready,
    input  logic                  tim_pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t state;

`ifdef APB_TMO_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] tmo_cnt;
`else
    assign rsp_tmo = 1'b0;
`endif

    // A new command is accepted only while idle.
    assign cmd_ready = (state == IDLE);

    // Request/response FSM. It owns all registered APB and response outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            tim_psel    <= 1'b0;
            tim_penable <= 1'b0;
            tim_pwrite  <= 1'b0;
            tim_paddr   <= '0;
            tim_pwdata  <= '0;
            tim_pstrb   <= '0;
`ifdef APB_TMO_EN
            rsp_tmo     <= 1'b0;
            tmo_cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
`ifdef APB_TMO_EN
                        rsp_tmo   <= 1'b0;
`endif
                        if (cmd_addr[1:0] != 2'b00) begin
                            // Misaligned: answer at once with an error and leave the bus untouched.
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            tim_psel    <= 1'b1;
                            tim_penable <= 1'b0;
                            tim_pwrite  <= cmd_write;
                            tim_paddr   <= cmd_addr;
                            tim_pwdata  <= cmd_wdata;
                            tim_pstrb   <= cmd_write ? cmd_strb : '0;
                            state       <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    tim_penable <= 1'b1;
`ifdef APB_TMO_EN
                    tmo_cnt     <= '0;
`endif
                    state       <= ACCESS;
                end
                ACCESS: begin
                    if (tim_pready) begin
                        tim_psel    <= 1'b0;
                        tim_penable <= 1'b0;
                        tim_pstrb   <= '0;
                        rsp_rdata   <= tim_pwrite ? '0 : tim_prdata;
                        rsp_err     <= tim_pslverr;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end
`ifdef APB_TMO_EN
                    else if (tmo_cnt + 8'd1 == TMO_LIMIT) begin
                        // This stalled edge brings the count to the limit, so the transfer aborts.
                        tmo_cnt     <= tmo_cnt + 8'd1;
                        tim_psel    <= 1'b0;
                        tim_penable <= 1'b0;
                        tim_pstrb   <= '0;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_tmo     <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        tmo_cnt     <= tmo_cnt + 8'd1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_timer_master.sv
// Testbench for apb_timer_master. It combines directed scenarios with a
// randomized phase. A transaction-level model tracks the expected outputs, and
// a compare process checks them on every falling edge.
module tb_apb_timer_master;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int SW     = DATA_W / 8;
    localparam int TMO    = 16;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic [SW-1:0]     cmd_strb = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_tmo;
    logic              tim_psel;
    logic              tim_penable;
    logic              tim_pwrite;
    logic [ADDR_W-1:0] tim_paddr;
    logic [DATA_W-1:0] tim_pwdata;
    logic [SW-1:0]     tim_pstrb;
    logic [DATA_W-1:0] tim_prdata = '0;
    logic              tim_pready = 1'b0;
    logic              tim_pslverr = 1'b0;

    apb_timer_master #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_tmo(rsp_tmo),
        .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
        .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
        .tim_prdata(tim_prdata), .tim_pready(tim_pready), .tim_pslverr(tim_pslverr)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding command with an age and a stall count.
    bit                m_busy = 0, m_mis = 0, m_done = 0, m_err = 0, m_tmo = 0;
    int                m_age = 0, m_stalls = 0;
    logic              m_pwrite = 0;
    logic [ADDR_W-1:0] m_paddr = '0;
    logic [DATA_W-1:0] m_pwdata = '0, m_rdata = '0;
    logic [SW-1:0]     m_strb = '0;

    initial forever begin
        @(posedge sys_clk);
        if (sys_rst) begin
            m_busy = 0; m_mis = 0; m_done = 0; m_err = 0; m_tmo = 0;
            m_rdata = '0; m_paddr = '0; m_pwdata = '0; m_pwrite = 0; m_strb = '0;
        end else if (!m_busy) begin
            if (cmd_valid) begin
                m_busy = 1; m_age = 0; m_stalls = 0;
                m_mis  = (int'(cmd_addr) % 4) != 0;
                m_done = m_mis; m_err = m_mis; m_tmo = 0; m_rdata = '0;
                if (!m_mis) begin
                    m_paddr = cmd_addr; m_pwdata = cmd_wdata; m_pwrite = cmd_write;
                    m_strb  = cmd_write ? cmd_strb : '0;
                end
            end
        end else if (!m_done) begin
            if (m_age == 0) begin
                m_age = 1;
            end else if (tim_pready) begin
                m_done = 1; m_err = tim_pslverr;
                m_rdata = m_pwrite ? '0 : tim_prdata;
            end else begin
                m_stalls++;
`ifdef APB_TMO_EN
                if (m_stalls == TMO) begin
                    m_done = 1; m_err = 1; m_tmo = 1; m_rdata = '0;
                end
`endif
            end
        end else if (rsp_ready) begin
            m_busy = 0;
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge sys_clk) begin
        if (chk_en) begin
            automatic bit e_psel = m_busy && !m_mis && !m_done;
            automatic bit e_pen  = e_psel && (m_age >= 1);
            automatic bit e_rv   = m_busy && m_done;
            chk("cmd_ready", 64'(cmd_ready), 64'(!m_busy));
            chk("psel", 64'(tim_psel), 64'(e_psel));
            chk("penable", 64'(tim_penable), 64'(e_pen));
            chk("pstrb", 64'(tim_pstrb), e_psel ? 64'(m_strb) : 64'(0));
            chk("paddr", 64'(tim_paddr), 64'(m_paddr));
            chk("pwdata", 64'(tim_pwdata), 64'(m_pwdata));
            chk("pwrite", 64'(tim_pwrite), 64'(m_pwrite));
            chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
            chk("rsp_err", 64'(rsp_err), 64'(m_err));
            chk("rsp_tmo", 64'(rsp_tmo), 64'(m_tmo));
            if (e_rv) chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge sys_clk);
    endtask

    task automatic send(input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [SW-1:0] s);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
    endtask

    initial begin
        int pen_cycles;

        // Reset
        step(); step();
        sys_rst = 0;
        chk_en  = 1;
        at_neg();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("rst_psel", 64'(tim_psel), 64'(0));
        chk("rst_penable", 64'(tim_penable), 64'(0));
        chk("rst_paddr", 64'(tim_paddr), 64'(0));
        chk("rst_pstrb", 64'(tim_pstrb), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));

        // Write with no wait states
        step();
        send(1, 12'h00C, 32'h0000_00FF, 4'hF);
        tim_pready = 1; rsp_ready = 1;
        step();
        cmd_valid = 0;
        at_neg();
        chk("w_psel_N", 64'(tim_psel), 64'(1));
        chk("w_pen_N", 64'(tim_penable), 64'(0));
        chk("w_pstrb", 64'(tim_pstrb), 64'(4'hF));
        chk("w_cmd_ready", 64'(cmd_ready), 64'(0));
        step(); at_neg();
        chk("w_pen_N1", 64'(tim_penable), 64'(1));
        chk("w_rv_N1", 64'(rsp_valid), 64'(0));
        step(); at_neg();
        chk("w_rv_N2", 64'(rsp_valid), 64'(1));
        chk("w_err", 64'(rsp_err), 64'(0));
        chk("w_psel_N2", 64'(tim_psel), 64'(0));
        step(); at_neg();
        chk("w_idle", 64'(cmd_ready), 64'(1));
        chk("w_paddr_hold", 64'(tim_paddr), 64'(12'h00C));

        // Read with three wait states
        step();
        send(0, 12'h004, 32'hDEAD_BEEF, 4'hF);
        tim_pready = 0; tim_prdata = 32'h0000_1234;
        step();
        cmd_valid = 0;
        at_neg();
        chk("r_pstrb", 64'(tim_pstrb), 64'(0));
        step();
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk("r_pen_hold", 64'(tim_penable), 64'(1));
            chk("r_paddr_hold", 64'(tim_paddr), 64'(12'h004));
            chk("r_pwrite_hold", 64'(tim_pwrite), 64'(0));
            if (i == 3) tim_pready = 1;
            step();
        end
        at_neg();
        chk("r_rv", 64'(rsp_valid), 64'(1));
        chk("r_rdata", 64'(rsp_rdata), 64'(32'h0000_1234));
        step();

        // Misaligned read
        send(0, 12'h006, 32'h0, 4'h0);
        step();
        cmd_valid = 0;
        at_neg();
        chk("mis_psel", 64'(tim_psel), 64'(0));
        chk("mis_rv", 64'(rsp_valid), 64'(1));
        chk("mis_err", 64'(rsp_err), 64'(1));
        chk("mis_rdata", 64'(rsp_rdata), 64'(0));
        step();

        // Slave error held under response backpressure, with a command offered in RESP
        send(1, 12'hFF0, 32'h5555_AAAA, 4'h3);
        tim_pready = 1; tim_pslverr = 1; rsp_ready = 0;
        step();
        cmd_valid = 0;
        step(); step();
        send(1, 12'h100, 32'h1, 4'hF);
        for (int i = 0; i < 5; i++) begin
            at_neg();
            chk("se_rv", 64'(rsp_valid), 64'(1));
            chk("se_err", 64'(rsp_err), 64'(1));
            chk("se_cmd_ready", 64'(cmd_ready), 64'(0));
            chk("se_psel", 64'(tim_psel), 64'(0));
            step();
        end
        cmd_valid = 0; tim_pslverr = 0; rsp_ready = 1;
        step(); at_neg();
        chk("se_idle", 64'(cmd_ready), 64'(1));
        chk("se_rv_drop", 64'(rsp_valid), 64'(0));

        // Slave that never asserts tim_pready
        step();
        send(0, 12'h010, 32'h0, 4'h0);
        tim_pready = 0; rsp_ready = 0;
        step();
        cmd_valid = 0;
        pen_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            at_neg();
            if (tim_penable) pen_cycles++;
            step();
        end
        at_neg();
`ifdef APB_TMO_EN
        chk("tmo_pen_cycles", 64'(pen_cycles), 64'(TMO));
        chk("tmo_rv", 64'(rsp_valid), 64'(1));
        chk("tmo_err", 64'(rsp_err), 64'(1));
        chk("tmo_flag", 64'(rsp_tmo), 64'(1));
        rsp_ready = 1;
        step();
`else
        chk("hang_pen_cycles", 64'(pen_cycles), 64'(99));
        chk("hang_psel", 64'(tim_psel), 64'(1));
        chk("hang_rv", 64'(rsp_valid), 64'(0));
        tim_pready = 1;
        step();
        rsp_ready = 1;
        step();
`endif

        // Reset during ACCESS, then a normal read
        send(0, 12'h020, 32'h0, 4'h0);
        tim_pready = 0;
        step();
        cmd_valid = 0;
        step(); step();
        at_neg();
        chk("ra_pen", 64'(tim_penable), 64'(1));
        sys_rst = 1;
        step();
        sys_rst = 0;
        at_neg();
        chk("ra_psel", 64'(tim_psel), 64'(0));
        chk("ra_pen0", 64'(tim_penable), 64'(0));
        chk("ra_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("ra_rv", 64'(rsp_valid), 64'(0));
        step();
        send(0, 12'h000, 32'h0, 4'h0);
        tim_pready = 1; tim_prdata = 32'hCAFE_F00D;
        step();
        cmd_valid = 0;
        step(); step();
        at_neg();
        chk("ra_read_rv", 64'(rsp_valid), 64'(1));
        chk("ra_read_rdata", 64'(rsp_rdata), 64'(32'hCAFE_F00D));
        step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cmd_valid   = ($urandom % 3) != 0;
            cmd_write   = $urandom % 2 == 1;
            cmd_addr    = ADDR_W'($urandom);
            if ($urandom % 8 != 0) cmd_addr[1:0] = 2'b00;
            cmd_wdata   = $urandom;
            cmd_strb    = SW'($urandom);
            tim_pready  = ($urandom % 100) < 55;
            tim_pslverr = ($urandom % 4) == 0;
            tim_prdata  = $urandom;
            rsp_ready   = ($urandom % 100) < 60;
            sys_rst     = ($urandom % 200) == 0;
            step();
        end
        sys_rst = 0; cmd_valid = 0;
        step();
        at_neg();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
